mul_seq_ctrl: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier controller.
- Sequences the processor's shared WIDTH-bit combinational adder, one partial-product add per clock, to form a 2*WIDTH-bit product.
- Sits between the ALU issue logic (start/operands) and the external adder: drives add_a/add_b and consumes add_result in the same cycle.

---
 rtl/mul_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiplier controller that drives a shared external WIDTH-bit adder.
// Optional two's-complement mode when SIGNED_MUL_EN is defined.
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SIGNED_MUL_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_result
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc_hi;
   logic [WIDTH-1:0] r_acc_lo;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   logic             w_run;
   logic             w_carry;
   logic             w_last;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;

`ifdef SIGNED_MUL_EN
   logic               r_neg;
   logic [2*WIDTH-1:0] w_neg_prod;

   // Magnitudes come from local negation so the shared adder stays free.
   assign w_a_mag    = (sgn && a[WIDTH-1]) ? ('0 - a) : a;
   assign w_b_mag    = (sgn && b[WIDTH-1]) ? ('0 - b) : b;
   assign w_neg_prod = '0 - {r_acc_hi, r_acc_lo};
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
`endif

   assign w_run   = (r_state == S_RUN);
   // The adder has no carry-out; a wrapped sum is smaller than its addend.
   assign w_carry = (add_result < r_acc_hi);
   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

   assign add_a = w_run ? r_acc_hi : '0;
   assign add_b = (w_run && r_acc_lo[0]) ? r_mcand : '0;

   assign busy       = r_busy;
   assign done       = r_done;
   assign product_hi = r_acc_hi;
   assign product_lo = r_acc_lo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef SIGNED_MUL_EN
         r_neg    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand  <= w_a_mag;
                  r_acc_hi <= '0;
                  r_acc_lo <= w_b_mag;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
`ifdef SIGNED_MUL_EN
                  r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
               end
            end
            S_RUN: begin
               {r_acc_hi, r_acc_lo} <= {w_carry, add_result, r_acc_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
`ifdef SIGNED_MUL_EN
                  r_state <= S_FIX;
`else
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
`endif
               end
            end
`ifdef SIGNED_MUL_EN
            S_FIX: begin
               if (r_neg) begin
                  {r_acc_hi, r_acc_lo} <= w_neg_prod;
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl; the external adder is modelled by a plain sum.
// Signed scenarios are exercised when SIGNED_MUL_EN is defined.
module tb_mul_seq_ctrl;

   localparam int WIDTH = 32;
`ifdef SIGNED_MUL_EN
   localparam int LAT = WIDTH + 1;
`else
   localparam int LAT = WIDTH;
`endif

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SIGNED_MUL_EN
   logic             sgn;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_result;

   int checks;
   int errors;

   assign add_result = add_a + add_b;

   mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
`ifdef SIGNED_MUL_EN
      .sgn        (sgn),
`endif
      .busy       (busy),
      .done       (done),
      .product_hi (product_hi),
      .product_lo (product_lo),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit s);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic [63:0]        ux;
      logic [63:0]        uy;
      if (s) begin
         sx = $signed(x);
         sy = $signed(y);
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
   endfunction

   // Called at posedge+1 with the DUT idle; returns one cycle after done, DUT idle again.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input bit ts,
                         input int pulse_at, input string name);
      logic [63:0] exp;
      exp   = ref_mul(ta, tb, ts);
      start = 1'b1;
      a     = ta;
      b     = tb;
`ifdef SIGNED_MUL_EN
      sgn   = ts;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk); #1;
         if (k < LAT) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s run: cycle %0d busy=%b done=%b, expected busy=1 done=0", name, k, busy, done);
            end
         end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s done: cycle %0d busy=%b done=%b, expected busy=0 done=1", name, k, busy, done);
            end
            checks++;
            if ({product_hi, product_lo} !== exp) begin
               errors++;
               $display("FAIL %s product: got %h_%h, expected %h_%h", name, product_hi, product_lo, exp[63:32], exp[31:0]);
            end
         end
         start = (k == pulse_at);
         if (k == pulse_at) begin
            a = 32'd7;
            b = 32'd7;
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {product_hi, product_lo} !== exp) begin
         errors++;
         $display("FAIL %s hold: busy=%b done=%b product=%h_%h, expected 0 0 %h_%h",
                  name, busy, done, product_hi, product_lo, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
`ifdef SIGNED_MUL_EN
      sgn   = 1'b0;
`endif
      #3;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product_hi !== '0 || product_lo !== '0 ||
          add_a !== '0 || add_b !== '0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b hi=%h lo=%h add_a=%h add_b=%h, expected all zero",
                  busy, done, product_hi, product_lo, add_a, add_b);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || add_a !== '0 || add_b !== '0) begin
         errors++;
         $display("FAIL idle: busy=%b add_a=%h add_b=%h, expected 0 0 0", busy, add_a, add_b);
      end
   endtask

   task automatic test_basic();
      run_op(32'd3, 32'd5, 1'b0, -1, "basic");
   endtask

   task automatic test_carry();
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "carry");
   endtask

   task automatic test_busy_hold();
      run_op(32'h1234_5678, 32'd0, 1'b0, 5, "busy_ignore");
      @(posedge clk); #1;
      checks++;
      if (product_hi !== '0 || product_lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL hold2: hi=%h lo=%h busy=%b done=%b, expected 0 0 0 0", product_hi, product_lo, busy, done);
      end
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      start = 1'b1;
      a     = 32'h0001_0000;
      b     = 32'h0001_0000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product_hi !== '0 || product_lo !== '0 ||
          add_a !== '0 || add_b !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h add_a=%h add_b=%h, expected all zero",
                  busy, done, product_hi, product_lo, add_a, add_b);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_abort: activity seen after abort=1, expected 0");
      end
      run_op(32'h0001_0000, 32'h0001_0000, 1'b0, -1, "after_reset");
   endtask

   task automatic test_back_to_back();
      int pulses[$];
      start = 1'b1;
      a     = 32'd2;
      b     = 32'd9;
`ifdef SIGNED_MUL_EN
      sgn   = 1'b0;
`endif
      @(posedge clk); #1;
      for (int k = 1; k <= 3 * (LAT + 2) + 4 && pulses.size() < 3; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            pulses.push_back(k);
            checks++;
            if (product_hi !== '0 || product_lo !== 32'h12) begin
               errors++;
               $display("FAIL b2b product: got %h_%h, expected 00000000_00000012", product_hi, product_lo);
            end
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (pulses.size() != 3) begin
         errors++;
         $display("FAIL b2b pulses: got %0d, expected 3", pulses.size());
      end else begin
         checks++;
         if (pulses[0] != LAT) begin
            errors++;
            $display("FAIL b2b first: cycle %0d, expected %0d", pulses[0], LAT);
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (pulses[i] - pulses[i-1] != LAT + 2) begin
               errors++;
               $display("FAIL b2b period: got %0d, expected %0d", pulses[i] - pulses[i-1], LAT + 2);
            end
         end
      end
   endtask

`ifdef SIGNED_MUL_EN
   task automatic test_signed();
      run_op(32'hFFFF_FFFD, 32'd7, 1'b1, -1, "signed_neg");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, "signed_min");
      run_op(32'h8000_0000, 32'd1, 1'b1, -1, "signed_min_one");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "signed_unsflag");
   endtask
`endif

   task automatic test_random();
      logic [31:0] ra;
      logic [31:0] rb;
      bit          rs;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       ra = '0;
            1:       ra = '1;
            2:       ra = 32'h8000_0000;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       rb = '1;
            1:       rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
`ifdef SIGNED_MUL_EN
         rs = ($urandom_range(0, 1) == 1);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, -1, "random");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_carry();
      test_busy_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef SIGNED_MUL_EN
      test_signed();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
